// File: rtl/voxel_pkg.sv
// rtl/voxel_pkg.sv - shared voxel memory constants and arbiter state type
package voxel_pkg;

    localparam int VOX_ADDR_W = 18;
    localparam int VOX_DATA_W = 64;
    localparam int GRID_SIZE  = 64;

    typedef enum logic {
        S_ARB  = 1'b0,
        S_LOCK = 1'b1
    } arb_state_t;

endpackage

// File: rtl/voxel_rr_picker.sv
// rtl/voxel_rr_picker.sv - combinational round-robin picker (rotate, priority, rotate back)
//
// Ports:
//   req     in   NUM_REQ  request vector
//   rr_ptr  in   ID_W     index that has highest priority this cycle (< NUM_REQ)
//   grant   out  NUM_REQ  one-hot grant, all zero when no request
//   winner  out  ID_W     index of the granted requester
//   any     out  1        at least one request present
module voxel_rr_picker #(
    parameter int NUM_REQ = 3,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    winner,
    output logic               any
);

    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   req_rot;
    logic [ID_W:0]        offset;
    logic [ID_W:0]        idx_sum;
    logic                 found;

    always_comb begin
        req_dbl = {req, req};
        // Rotating right by rr_ptr puts requester rr_ptr at bit 0.
        req_rot = req_dbl[rr_ptr +: NUM_REQ];
        any     = |req;
        offset  = '0;
        found   = 1'b0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!found && req_rot[j]) begin
                offset = (ID_W+1)'(j);
                found  = 1'b1;
            end
        end
        // Rotate the found position back into requester numbering.
        idx_sum = {1'b0, rr_ptr} + offset;
        if (idx_sum >= (ID_W+1)'(NUM_REQ)) begin
            idx_sum = idx_sum - (ID_W+1)'(NUM_REQ);
        end
        winner = idx_sum[ID_W-1:0];
        grant  = '0;
        if (any) begin
            grant[winner] = 1'b1;
        end
    end

endmodule

// File: rtl/voxel_write_arbiter.sv
// rtl/voxel_write_arbiter.sv - round-robin write-port arbiter with owner lock, in front of voxel_memory_64
//
// Optional build macro: VOXEL_WR_ARB_STATS_EN adds per-requester beat counters and port stat_beats.
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   req_valid    per-requester write beat present
//   req_ready    per-requester combinational grant (at most one bit set)
//   req_lock     per-requester request to keep ownership after this beat
//   req_addr     packed 18-bit addresses, slice i = [18*i +: 18]
//   req_data     packed 64-bit words,     slice i = [64*i +: 64]
//   write_addr   registered memory write address
//   write_data   registered memory write data
//   write_en     one-cycle write strobe, one cycle after accept
//   grant_id     requester index of last accepted beat
//   locked       high while a requester owns the port
//   stat_beats   (stats build only) 32-bit saturating accepted-beat count per requester
module voxel_write_arbiter
    import voxel_pkg::*;
#(
    parameter int NUM_REQ  = 3,
    parameter int LOCK_MAX = 4096,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ-1:0]         req_lock,
    input  logic [NUM_REQ*18-1:0]      req_addr,
    input  logic [NUM_REQ*64-1:0]      req_data,
    output logic [VOX_ADDR_W-1:0]      write_addr,
    output logic [VOX_DATA_W-1:0]      write_data,
    output logic                       write_en,
    output logic [ID_W-1:0]            grant_id,
    output logic                       locked
`ifdef VOXEL_WR_ARB_STATS_EN
    ,
    output logic [NUM_REQ*32-1:0]      stat_beats
`endif
);

    localparam int                CNT_W    = $clog2(LOCK_MAX + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(LOCK_MAX - 1);
    localparam bit                LOCK_EN  = (LOCK_MAX > 1);

    arb_state_t             state_q, state_d;
    logic [ID_W-1:0]        rr_ptr;
    logic [ID_W-1:0]        owner;
    logic [CNT_W-1:0]       lock_cnt;

    logic [NUM_REQ-1:0]     pick_grant;
    logic [ID_W-1:0]        pick_id;
    logic                   pick_any;
    logic                   accept;
    logic [ID_W-1:0]        win_id;
    logic [VOX_ADDR_W-1:0]  sel_addr;
    logic [VOX_DATA_W-1:0]  sel_data;

    voxel_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .req    (req_valid),
        .rr_ptr (rr_ptr),
        .grant  (pick_grant),
        .winner (pick_id),
        .any    (pick_any)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_ARB;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_ARB: begin
                if (LOCK_EN && pick_any && req_lock[pick_id]) begin
                    state_d = S_LOCK;
                end
            end
            S_LOCK: begin
                // Dropping lock releases even without a beat; the cap only counts accepted beats.
                if (!req_lock[owner] || (req_valid[owner] && lock_cnt == CNT_LAST)) begin
                    state_d = S_ARB;
                end
            end
            default: state_d = S_ARB;
        endcase
    end

    // Output logic: grants come only from registered state, never from req_ready itself.
    always_comb begin
        req_ready = '0;
        if (state_q == S_LOCK) begin
            req_ready[owner] = req_valid[owner];
        end else begin
            req_ready = pick_grant;
        end
        locked = (state_q == S_LOCK);
        accept = (state_q == S_LOCK) ? req_valid[owner] : pick_any;
        win_id = (state_q == S_LOCK) ? owner : pick_id;
    end

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_id == ID_W'(i)) begin
                sel_addr = req_addr[VOX_ADDR_W*i +: VOX_ADDR_W];
                sel_data = req_data[VOX_DATA_W*i +: VOX_DATA_W];
            end
        end
    end

    // Pointer, owner and burst length bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr   <= '0;
            owner    <= '0;
            lock_cnt <= '0;
        end else begin
            if (accept) begin
                rr_ptr <= (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + ID_W'(1);
            end
            if (state_q == S_ARB && state_d == S_LOCK) begin
                owner    <= win_id;
                lock_cnt <= CNT_W'(1);
            end else if (state_q == S_LOCK && state_d == S_ARB) begin
                lock_cnt <= '0;
            end else if (state_q == S_LOCK && accept) begin
                lock_cnt <= lock_cnt + CNT_W'(1);
            end
        end
    end

    // Registered memory write port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            write_en   <= 1'b0;
            write_addr <= '0;
            write_data <= '0;
            grant_id   <= '0;
        end else begin
            write_en <= accept;
            if (accept) begin
                write_addr <= sel_addr;
                write_data <= sel_data;
                grant_id   <= win_id;
            end
        end
    end

`ifdef VOXEL_WR_ARB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_beats <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_ready[i] && stat_beats[32*i +: 32] != 32'hFFFF_FFFF) begin
                    stat_beats[32*i +: 32] <= stat_beats[32*i +: 32] + 32'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_voxel_write_arbiter.sv
// tb/tb_voxel_write_arbiter.sv - directed self-checking bench for voxel_write_arbiter
module tb_voxel_write_arbiter;

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    req_valid;
    logic [2:0]    req_lock;
    logic [53:0]   req_addr;
    logic [191:0]  req_data;

    logic [2:0]    ready, ready4;
    logic [17:0]   waddr, waddr4;
    logic [63:0]   wdata, wdata4;
    logic          wen, wen4;
    logic [1:0]    gid, gid4;
    logic          lkd, lkd4;
`ifdef VOXEL_WR_ARB_STATS_EN
    logic [95:0]   stats, stats4;
`endif

    voxel_write_arbiter #(.NUM_REQ(3)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (ready),
        .req_lock   (req_lock),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .write_addr (waddr),
        .write_data (wdata),
        .write_en   (wen),
        .grant_id   (gid),
        .locked     (lkd)
`ifdef VOXEL_WR_ARB_STATS_EN
        ,
        .stat_beats (stats)
`endif
    );

    voxel_write_arbiter #(.NUM_REQ(3), .LOCK_MAX(4)) u_dut4 (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (ready4),
        .req_lock   (req_lock),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .write_addr (waddr4),
        .write_data (wdata4),
        .write_en   (wen4),
        .grant_id   (gid4),
        .locked     (lkd4)
`ifdef VOXEL_WR_ARB_STATS_EN
        ,
        .stat_beats (stats4)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_valid = '0;
        req_lock  = '0;
        rst       = 1'b1;
        cyc();
        rst       = 1'b0;
    endtask

    int wen_cnt;

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_lock  = '0;
        for (int i = 0; i < 3; i++) begin
            req_addr[18*i +: 18] = 18'h1000 + 18'(i);
            req_data[64*i +: 64] = 64'hDA7A_0000_0000_0000 + 64'(i);
        end
        cyc();
        cyc();
        chk("rst_wen", 64'(wen), 64'd0);
        chk("rst_addr", 64'(waddr), 64'd0);
        chk("rst_data", wdata, 64'd0);
        chk("rst_gid", 64'(gid), 64'd0);
        chk("rst_locked", 64'(lkd), 64'd0);
        rst = 1'b0;

        // 1: all valid, no lock -> rotation 0,1,2,0,1,2
        req_valid = 3'b111;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("t1_ready", 64'(ready), 64'(3'b001 << (k % 3)));
            cyc();
            chk("t1_wen", 64'(wen), 64'd1);
            chk("t1_gid", 64'(gid), 64'(k % 3));
            chk("t1_addr", 64'(waddr), 64'(18'h1000 + 18'(k % 3)));
            chk("t1_data", wdata, 64'hDA7A_0000_0000_0000 + 64'(k % 3));
        end
        req_valid = 3'b000;
        cyc();
        chk("t1_idle_wen", 64'(wen), 64'd0);

        // 2: req1 locked burst of 10 beats while 0 and 2 are valid
        do_reset();
        req_valid = 3'b001;
        cyc();
        req_valid = 3'b111;
        for (int b = 0; b < 10; b++) begin
            req_lock = (b < 9) ? 3'b010 : 3'b000;
            #1;
            chk("t2_ready", 64'(ready), 64'(3'b010));
            cyc();
            chk("t2_wen", 64'(wen), 64'd1);
            chk("t2_gid", 64'(gid), 64'd1);
            if (b < 9) chk("t2_locked", 64'(lkd), 64'd1);
        end
        chk("t2_released", 64'(lkd), 64'd0);
        #1;
        chk("t2_ready_r2", 64'(ready), 64'(3'b100));
        cyc();
        chk("t2_gid_r2", 64'(gid), 64'd2);
        #1;
        chk("t2_ready_r0", 64'(ready), 64'(3'b001));
        cyc();
        chk("t2_gid_r0", 64'(gid), 64'd0);

        // 3: LOCK_MAX=4 forced release, req0 holds lock, req1 valid
        do_reset();
        req_valid = 3'b011;
        req_lock  = 3'b001;
        for (int b = 0; b < 4; b++) begin
            #1;
            chk("t3_ready0", 64'(ready4), 64'(3'b001));
            cyc();
            chk("t3_gid0", 64'(gid4), 64'd0);
            chk("t3_wen", 64'(wen4), 64'd1);
        end
        chk("t3_forced", 64'(lkd4), 64'd0);
        #1;
        chk("t3_ready1", 64'(ready4), 64'(3'b010));
        cyc();
        chk("t3_gid1", 64'(gid4), 64'd1);
        #1;
        chk("t3_relock_ready", 64'(ready4), 64'(3'b001));
        cyc();
        chk("t3_relock", 64'(lkd4), 64'd1);

        // 4: owner bubbles for 3 cycles with lock held
        do_reset();
        req_valid = 3'b001;
        req_lock  = 3'b001;
        #1;
        chk("t4_ready", 64'(ready), 64'(3'b001));
        cyc();
        chk("t4_locked", 64'(lkd), 64'd1);
        req_valid = 3'b110;
        for (int b = 0; b < 3; b++) begin
            #1;
            chk("t4_stall_ready", 64'(ready), 64'd0);
            cyc();
            chk("t4_bubble_wen", 64'(wen), 64'd0);
            chk("t4_hold", 64'(lkd), 64'd1);
        end
        req_valid = 3'b111;
        #1;
        chk("t4_resume_ready", 64'(ready), 64'(3'b001));
        cyc();
        chk("t4_resume_wen", 64'(wen), 64'd1);
        req_lock = 3'b000;
        #1;
        chk("t4_final_ready", 64'(ready), 64'(3'b001));
        cyc();
        chk("t4_final_wen", 64'(wen), 64'd1);
        chk("t4_unlocked", 64'(lkd), 64'd0);
        #1;
        chk("t4_next_ready", 64'(ready), 64'(3'b010));

        // 5: reset during a locked burst at beat 5
        do_reset();
        req_valid = 3'b111;
        req_lock  = 3'b001;
        for (int b = 0; b < 4; b++) cyc();
        #1;
        chk("t5_beat5_ready", 64'(ready), 64'(3'b001));
        chk("t5_beat5_locked", 64'(lkd), 64'd1);
        rst = 1'b1;
        #1;
        chk("t5_async_wen", 64'(wen), 64'd0);
        cyc();
        chk("t5_wen", 64'(wen), 64'd0);
        chk("t5_addr", 64'(waddr), 64'd0);
        chk("t5_data", wdata, 64'd0);
        chk("t5_locked", 64'(lkd), 64'd0);
        rst       = 1'b0;
        req_valid = 3'b110;
        req_lock  = 3'b000;
        #1;
        chk("t5_first_ready", 64'(ready), 64'(3'b010));
        cyc();
        chk("t5_first_gid", 64'(gid), 64'd1);
        chk("t5_first_addr", 64'(waddr), 64'(18'h1001));

        // 6: 100 beats from req2 then 37 from req0
        do_reset();
        wen_cnt   = 0;
        req_valid = 3'b100;
        for (int b = 0; b < 100; b++) begin
            cyc();
            if (wen) wen_cnt++;
        end
        req_valid = 3'b001;
        for (int b = 0; b < 37; b++) begin
            cyc();
            if (wen) wen_cnt++;
        end
        req_valid = 3'b000;
        cyc();
        if (wen) wen_cnt++;
        chk("t6_wen_count", 64'(wen_cnt), 64'd137);
`ifdef VOXEL_WR_ARB_STATS_EN
        chk("t6_stat2", 64'(stats[64 +: 32]), 64'd100);
        chk("t6_stat1", 64'(stats[32 +: 32]), 64'd0);
        chk("t6_stat0", 64'(stats[0 +: 32]), 64'd37);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
